io_bus_initiator: RTL and testbench
===================================

# io_bus_initiator

Single-master initiator for the on-chip IO bus: the requesting end of the `AIoAddr`/`AIoMosi`/`AIoMiso`/`AIoWrSize`/`AIoRdSize`/`AIoAddrAck`/`AIoAddrErr` interface that peripherals such as the timers respond to. It accepts read/write commands through a valid/ready port and queues them in a small FIFO. Each command becomes one single-cycle bus access. The block returns read data and an access status through a valid/ready response port. It sits between a host-side sequencer (debug bridge, boot loader, DMA-lite engine) and the IO peripheral fabric.

## Interface
- `CCmdDepth`, default 4: command FIFO depth; power of 2, ≥2.
- `AClkH`  in  1  clock.
- `AResetH`  in  1  asynchronous reset, active-high.
- `AClkHEn`  in  1  clock enable; no register updates while 0.
- `ACmdVld`  in  1  command valid.
- `ACmdRdy`  out  1  command ready; equals FIFO not full.
- `ACmdWr`  in  1  1 = write, 0 = read.
- `ACmdSize`  in  2  size: 0 = byte, 1 = word, 2 = dword, 3 = qword.
- `ACmdAddr`  in  16  IO address.
- `ACmdData`  in  64  write data, LSB-aligned.
- `ARspVld`  out  1  response valid.
- `ARspRdy`  in  1  response ready.
- `ARspData`  out  64  read data masked to size; 0 for writes.
- `ARspStat`  out  2  00 ok, 01 size error, 10 no responder, 11 protocol violation.
- `ARspWr`  out  1  echo of the command's `ACmdWr`.
- `AIoAddr`  out  16  bus address.
- `AIoMosi`  out  64  bus write data.
- `AIoWrSize`  out  4  one-hot write size: bit0 B, bit1 W, bit2 D, bit3 Q.
- `AIoRdSize`  out  4  one-hot read size, same encoding.
- `AIoMiso`  in  64  bus read data (OR of responders).
- `AIoAddrAck`  in  1  responder claims the access.
- `AIoAddrErr`  in  1  address decoded but size or direction illegal.
- `AErrSticky`  out  1  sticky error flag (see Configuration).
- `AErrClr`  in  1  clears `AErrSticky`.

## Operation
- Command FIFO:
  - Push on `ACmdVld & ACmdRdy & AClkHEn`.
  - Entry holds {wr, size, addr, data}.
- FSM states: IDLE, ACCESS, HALT (HALT only with the macro).
- IDLE:
  - Issue when the FIFO is non-empty and the response slot is free. The slot is free when `ARspVld`=0, or when `ARspVld & ARspRdy` in this cycle.
  - On issue: pop the head and load the bus registers, then go to ACCESS.
  - Bus register values:
    - `AIoAddr` = addr.
    - `AIoMosi` = data with bits above the size width zeroed, or 0 for reads.
    - The one-hot size goes on `AIoWrSize` or `AIoRdSize` per wr; the other size bus is 0.
- ACCESS (exactly one cycle):
  - Sample `AIoMiso`, `AIoAddrAck` and `AIoAddrErr` at the closing edge.
  - Load the response: data = Miso masked to size (0 for writes).
  - Status: ack&!err = 00, !ack&err = 01, !ack&!err = 10, ack&err = 11.
  - Set `ARspVld`, clear the bus registers to 0, then go to IDLE.
- Response slot: `ARspVld` clears on `ARspVld & ARspRdy` unless a new response loads in the same cycle.
- Simultaneous FIFO push and pop: both take effect; occupancy is unchanged.
- Reset mid-access:
  - All state clears immediately (asynchronous).
  - The access in flight is dropped and no response is produced.
  - FIFO contents are discarded.

## Timing
- Reset values:
  - `ACmdRdy`=1.
  - `ARspVld`=0, `ARspData`=0, `ARspStat`=00, `ARspWr`=0.
  - `AIoAddr`=0, `AIoMosi`=0, `AIoWrSize`=0, `AIoRdSize`=0.
  - `AErrSticky`=0.
  - FSM in IDLE.
- Bus outputs are registered; `AIoWrSize|AIoRdSize` is non-zero only in ACCESS cycles.
- Latency, with an empty FIFO and a free slot:
  - Command accepted at edge E0.
  - Bus access occupies the cycle E1–E2.
  - `ARspVld`=1 after E2.
- Throughput: one access per 2 cycles while `ARspRdy`=1.
- Back-pressure: while `ARspVld`=1 and `ARspRdy`=0, no access issues. The FIFO continues to fill until `ACmdRdy`=0.
- When `AClkHEn`=0 all state freezes. Bus outputs hold, so an ACCESS cycle stretches until the enable returns.

## Configuration
- `IO_INITIATOR_HALT_ON_ERR_EN` defined:
  - Any nonzero status loaded into the response sets `AErrSticky`.
  - The FSM goes ACCESS→HALT instead of IDLE.
  - HALT issues nothing while the FIFO keeps accepting commands.
  - `AErrClr`=1 clears `AErrSticky` and returns HALT→IDLE on the next enabled edge.
  - If `AErrClr` coincides with a new error, set wins.
- Undefined:
  - `AErrSticky` is tied to 0 and `AErrClr` is ignored.
  - Errors are reported per response only, and the queue keeps executing.

## Test plan
- Write of size word, addr 0x0011, data 0xDEADBEEF_12345678, responder acks → `AIoWrSize`=0010 and `AIoMosi`=0x5678 for one cycle; response stat 00, data 0.
- Read of size byte at 0x0000, `AIoMiso`=0xFFFF_FFFF_FFFF_FFA5 with ack → `ARspData`=0xA5, stat 00, `ARspVld` 2 cycles after accept.
- Push 5 commands with `ARspRdy`=0 and depth 4 → 1 access issues, 4 queued, `ACmdRdy`=0. Raise `ARspRdy` → remaining responses arrive in order, one every 2 cycles.
- Read at an unmapped address (no ack, no err) → stat 10. Access with err only → stat 01. With the macro: `AErrSticky`=1, the next queued command is not issued until an `AErrClr` pulse.
- Assert `AResetH` during an ACCESS cycle with 2 commands queued → all bus outputs 0 immediately, `ARspVld`=0, `ACmdRdy`=1, no response after release.

Source files
------------

// File: rtl/io_bus_initiator.sv
// Single-master IO bus initiator: queued valid/ready commands become one-cycle bus accesses with a response slot.
// Optional halt-on-error behaviour is enabled with `define IO_INITIATOR_HALT_ON_ERR_EN.
module io_bus_initiator #(
  parameter int CCmdDepth = 4
) (
  input  logic        AClkH,
  input  logic        AResetH,
  input  logic        AClkHEn,
  input  logic        ACmdVld,
  output logic        ACmdRdy,
  input  logic        ACmdWr,
  input  logic [1:0]  ACmdSize,
  input  logic [15:0] ACmdAddr,
  input  logic [63:0] ACmdData,
  output logic        ARspVld,
  input  logic        ARspRdy,
  output logic [63:0] ARspData,
  output logic [1:0]  ARspStat,
  output logic        ARspWr,
  output logic [15:0] AIoAddr,
  output logic [63:0] AIoMosi,
  output logic [3:0]  AIoWrSize,
  output logic [3:0]  AIoRdSize,
  input  logic [63:0] AIoMiso,
  input  logic        AIoAddrAck,
  input  logic        AIoAddrErr,
  output logic        AErrSticky,
  input  logic        AErrClr
);

  localparam int AW = (CCmdDepth > 1) ? $clog2(CCmdDepth) : 1;
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DepthC = CW'(CCmdDepth);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    HALT   = 2'd2
  } state_e;

  typedef struct packed {
    logic        wr;
    logic [1:0]  size;
    logic [15:0] addr;
    logic [63:0] data;
  } cmd_t;

  cmd_t          fifo_mem [CCmdDepth];
  cmd_t          head;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  state_e        state_q, state_d;

  logic [15:0]   io_addr_q, io_addr_d;
  logic [63:0]   io_mosi_q, io_mosi_d;
  logic [3:0]    io_wr_size_q, io_wr_size_d;
  logic [3:0]    io_rd_size_q, io_rd_size_d;
  logic          acc_wr_q, acc_wr_d;
  logic [1:0]    acc_size_q, acc_size_d;

  logic          rsp_vld_q, rsp_vld_d;
  logic [63:0]   rsp_data_q, rsp_data_d;
  logic [1:0]    rsp_stat_q, rsp_stat_d;
  logic          rsp_wr_q, rsp_wr_d;
  logic          sticky_q, sticky_d;

  logic          push, issue, slot_free;
  logic [1:0]    bus_stat;

  function automatic logic [63:0] size_mask(input logic [1:0] s);
    case (s)
      2'd0:    return 64'h0000_0000_0000_00FF;
      2'd1:    return 64'h0000_0000_0000_FFFF;
      2'd2:    return 64'h0000_0000_FFFF_FFFF;
      default: return 64'hFFFF_FFFF_FFFF_FFFF;
    endcase
  endfunction

  function automatic logic [3:0] size_onehot(input logic [1:0] s);
    return 4'b0001 << s;
  endfunction

  assign ACmdRdy    = (cnt_q != DepthC);
  assign push       = ACmdVld & ACmdRdy & AClkHEn;
  assign slot_free  = ~rsp_vld_q | ARspRdy;
  assign head       = fifo_mem[rd_ptr_q];

  always_comb begin
    case ({AIoAddrAck, AIoAddrErr})
      2'b10:   bus_stat = 2'b00;
      2'b01:   bus_stat = 2'b01;
      2'b00:   bus_stat = 2'b10;
      default: bus_stat = 2'b11;
    endcase
  end

  // Storage only; validity is tracked by the pointers so reset need not clear it.
  always_ff @(posedge AClkH) begin
    if (push) begin
      fifo_mem[wr_ptr_q] <= '{wr: ACmdWr, size: ACmdSize, addr: ACmdAddr, data: ACmdData};
    end
  end

  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    cnt_d        = cnt_q;
    io_addr_d    = io_addr_q;
    io_mosi_d    = io_mosi_q;
    io_wr_size_d = io_wr_size_q;
    io_rd_size_d = io_rd_size_q;
    acc_wr_d     = acc_wr_q;
    acc_size_d   = acc_size_q;
    rsp_vld_d    = rsp_vld_q;
    rsp_data_d   = rsp_data_q;
    rsp_stat_d   = rsp_stat_q;
    rsp_wr_d     = rsp_wr_q;
    sticky_d     = sticky_q;
    issue        = 1'b0;

    if (AClkHEn) begin
      if (rsp_vld_q && ARspRdy) begin
        rsp_vld_d = 1'b0;
      end

      case (state_q)
        IDLE: begin
          if ((cnt_q != '0) && slot_free) begin
            issue        = 1'b1;
            io_addr_d    = head.addr;
            io_mosi_d    = head.wr ? (head.data & size_mask(head.size)) : 64'h0;
            io_wr_size_d = head.wr ? size_onehot(head.size) : 4'b0000;
            io_rd_size_d = head.wr ? 4'b0000 : size_onehot(head.size);
            acc_wr_d     = head.wr;
            acc_size_d   = head.size;
            state_d      = ACCESS;
          end
        end
        ACCESS: begin
          rsp_vld_d    = 1'b1;
          rsp_data_d   = acc_wr_q ? 64'h0 : (AIoMiso & size_mask(acc_size_q));
          rsp_stat_d   = bus_stat;
          rsp_wr_d     = acc_wr_q;
          io_addr_d    = 16'h0;
          io_mosi_d    = 64'h0;
          io_wr_size_d = 4'b0000;
          io_rd_size_d = 4'b0000;
          state_d      = IDLE;
`ifdef IO_INITIATOR_HALT_ON_ERR_EN
          if (bus_stat != 2'b00) begin
            state_d = HALT;
          end
`endif
        end
        HALT: begin
`ifdef IO_INITIATOR_HALT_ON_ERR_EN
          if (AErrClr) begin
            state_d = IDLE;
          end
`else
          state_d = IDLE;
`endif
        end
        default: state_d = IDLE;
      endcase

`ifdef IO_INITIATOR_HALT_ON_ERR_EN
      // A fresh error outranks a simultaneous clear.
      if ((state_q == ACCESS) && (bus_stat != 2'b00)) begin
        sticky_d = 1'b1;
      end else if (AErrClr) begin
        sticky_d = 1'b0;
      end
`endif

      if (push) begin
        wr_ptr_d = wr_ptr_q + AW'(1);
      end
      if (issue) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end
      cnt_d = cnt_q + CW'(push) - CW'(issue);
    end
  end

  always_ff @(posedge AClkH or posedge AResetH) begin
    if (AResetH) begin
      state_q      <= IDLE;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      cnt_q        <= '0;
      io_addr_q    <= 16'h0;
      io_mosi_q    <= 64'h0;
      io_wr_size_q <= 4'b0000;
      io_rd_size_q <= 4'b0000;
      acc_wr_q     <= 1'b0;
      acc_size_q   <= 2'b00;
      rsp_vld_q    <= 1'b0;
      rsp_data_q   <= 64'h0;
      rsp_stat_q   <= 2'b00;
      rsp_wr_q     <= 1'b0;
      sticky_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      cnt_q        <= cnt_d;
      io_addr_q    <= io_addr_d;
      io_mosi_q    <= io_mosi_d;
      io_wr_size_q <= io_wr_size_d;
      io_rd_size_q <= io_rd_size_d;
      acc_wr_q     <= acc_wr_d;
      acc_size_q   <= acc_size_d;
      rsp_vld_q    <= rsp_vld_d;
      rsp_data_q   <= rsp_data_d;
      rsp_stat_q   <= rsp_stat_d;
      rsp_wr_q     <= rsp_wr_d;
      sticky_q     <= sticky_d;
    end
  end

`ifndef IO_INITIATOR_HALT_ON_ERR_EN
  logic unused_err_clr;
  assign unused_err_clr = AErrClr;
`endif

  assign AIoAddr    = io_addr_q;
  assign AIoMosi    = io_mosi_q;
  assign AIoWrSize  = io_wr_size_q;
  assign AIoRdSize  = io_rd_size_q;
  assign ARspVld    = rsp_vld_q;
  assign ARspData   = rsp_data_q;
  assign ARspStat   = rsp_stat_q;
  assign ARspWr     = rsp_wr_q;
  assign AErrSticky = sticky_q;

endmodule

// File: tb/tb_io_bus_initiator.sv
// Directed self-checking bench for io_bus_initiator; outputs are sampled 1 time unit after each rising edge.
module tb_io_bus_initiator;

  logic        AClkH = 1'b0;
  logic        AResetH, AClkHEn, ACmdVld, ACmdRdy, ACmdWr;
  logic [1:0]  ACmdSize;
  logic [15:0] ACmdAddr;
  logic [63:0] ACmdData;
  logic        ARspVld, ARspRdy, ARspWr;
  logic [63:0] ARspData;
  logic [1:0]  ARspStat;
  logic [15:0] AIoAddr;
  logic [63:0] AIoMosi, AIoMiso;
  logic [3:0]  AIoWrSize, AIoRdSize;
  logic        AIoAddrAck, AIoAddrErr, AErrSticky, AErrClr;

  logic        miso_echo;
  logic [63:0] miso_val;
  int          n_assert = 0;
  int          n_fail   = 0;

  io_bus_initiator #(.CCmdDepth(4)) dut (
    .AClkH(AClkH), .AResetH(AResetH), .AClkHEn(AClkHEn),
    .ACmdVld(ACmdVld), .ACmdRdy(ACmdRdy), .ACmdWr(ACmdWr), .ACmdSize(ACmdSize),
    .ACmdAddr(ACmdAddr), .ACmdData(ACmdData),
    .ARspVld(ARspVld), .ARspRdy(ARspRdy), .ARspData(ARspData), .ARspStat(ARspStat), .ARspWr(ARspWr),
    .AIoAddr(AIoAddr), .AIoMosi(AIoMosi), .AIoWrSize(AIoWrSize), .AIoRdSize(AIoRdSize),
    .AIoMiso(AIoMiso), .AIoAddrAck(AIoAddrAck), .AIoAddrErr(AIoAddrErr),
    .AErrSticky(AErrSticky), .AErrClr(AErrClr)
  );

  always #5 AClkH = ~AClkH;

  // Responder: either echoes the bus address into every lane or drives a fixed pattern.
  always_comb AIoMiso = miso_echo ? {4{AIoAddr}} : miso_val;

  task automatic step();
    @(posedge AClkH);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic wr, input logic [1:0] sz, input logic [15:0] a, input logic [63:0] d);
    ACmdVld  = 1'b1;
    ACmdWr   = wr;
    ACmdSize = sz;
    ACmdAddr = a;
    ACmdData = d;
    step();
    ACmdVld  = 1'b0;
  endtask

`ifdef IO_INITIATOR_HALT_ON_ERR_EN
  task automatic clear_halt();
    AErrClr = 1'b1;
    step();
    AErrClr = 1'b0;
    chk("halt_clr_sticky", 64'(AErrSticky), 64'h0);
  endtask
`endif

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected end of test");
    $fatal(1, "watchdog");
  end

  initial begin
    AResetH    = 1'b1;
    AClkHEn    = 1'b1;
    ACmdVld    = 1'b0;
    ACmdWr     = 1'b0;
    ACmdSize   = 2'd0;
    ACmdAddr   = 16'h0;
    ACmdData   = 64'h0;
    ARspRdy    = 1'b1;
    AIoAddrAck = 1'b1;
    AIoAddrErr = 1'b0;
    AErrClr    = 1'b0;
    miso_echo  = 1'b0;
    miso_val   = 64'h0;

    repeat (2) step();
    chk("rst_cmdrdy",  64'(ACmdRdy), 64'h1);
    chk("rst_rspvld",  64'(ARspVld), 64'h0);
    chk("rst_rspdata", ARspData, 64'h0);
    chk("rst_rspstat", 64'(ARspStat), 64'h0);
    chk("rst_rspwr",   64'(ARspWr), 64'h0);
    chk("rst_ioaddr",  64'(AIoAddr), 64'h0);
    chk("rst_mosi",    AIoMosi, 64'h0);
    chk("rst_wrsize",  64'(AIoWrSize), 64'h0);
    chk("rst_rdsize",  64'(AIoRdSize), 64'h0);
    chk("rst_sticky",  64'(AErrSticky), 64'h0);
    AResetH = 1'b0;
    step();

    // Word write: bus occupied one cycle after accept, response one cycle later.
    send(1'b1, 2'd1, 16'h0011, 64'hDEADBEEF_12345678);
    chk("wr_bus_idle_e0", 64'(AIoWrSize), 64'h0);
    step();
    chk("wr_wrsize", 64'(AIoWrSize), 64'h2);
    chk("wr_rdsize", 64'(AIoRdSize), 64'h0);
    chk("wr_mosi",   AIoMosi, 64'h5678);
    chk("wr_addr",   64'(AIoAddr), 64'h0011);
    chk("wr_rsp_not_yet", 64'(ARspVld), 64'h0);
    step();
    chk("wr_rspvld",  64'(ARspVld), 64'h1);
    chk("wr_rspstat", 64'(ARspStat), 64'h0);
    chk("wr_rspdata", ARspData, 64'h0);
    chk("wr_rspwr",   64'(ARspWr), 64'h1);
    chk("wr_bus_cleared", 64'(AIoWrSize), 64'h0);
    chk("wr_mosi_cleared", AIoMosi, 64'h0);
    step();
    chk("wr_rsp_consumed", 64'(ARspVld), 64'h0);

    // Byte read: data masked to the low byte.
    miso_val = 64'hFFFF_FFFF_FFFF_FFA5;
    send(1'b0, 2'd0, 16'h0000, 64'h1234);
    step();
    chk("rd_rdsize", 64'(AIoRdSize), 64'h1);
    chk("rd_wrsize", 64'(AIoWrSize), 64'h0);
    chk("rd_mosi",   AIoMosi, 64'h0);
    step();
    chk("rd_rspvld",  64'(ARspVld), 64'h1);
    chk("rd_rspdata", ARspData, 64'hA5);
    chk("rd_rspstat", 64'(ARspStat), 64'h0);
    chk("rd_rspwr",   64'(ARspWr), 64'h0);
    step();

    // Back-pressure: five dword reads with the response port stalled.
    ARspRdy   = 1'b0;
    miso_echo = 1'b1;
    ACmdVld   = 1'b1;
    ACmdWr    = 1'b0;
    ACmdSize  = 2'd2;
    for (int i = 0; i < 5; i++) begin
      ACmdAddr = 16'h0100 + 16'(i);
      step();
    end
    ACmdVld = 1'b0;
    chk("bp_full",     64'(ACmdRdy), 64'h0);
    chk("bp_rspvld",   64'(ARspVld), 64'h1);
    chk("bp_rsp0",     ARspData, 64'h0000_0000_0100_0100);
    repeat (2) step();
    chk("bp_no_issue", 64'(AIoRdSize), 64'h0);
    chk("bp_rsp_held", ARspData, 64'h0000_0000_0100_0100);
    ARspRdy = 1'b1;
    for (int i = 1; i < 5; i++) begin
      step();
      chk("bp_gap_vld", 64'(ARspVld), 64'h0);
      chk("bp_access",  64'(AIoRdSize), 64'h4);
      step();
      chk("bp_vld",  64'(ARspVld), 64'h1);
      chk("bp_data", ARspData, {32'h0, 16'h0100 + 16'(i), 16'h0100 + 16'(i)});
    end
    step();
    chk("bp_drained_vld", 64'(ARspVld), 64'h0);
    chk("bp_drained_rdy", 64'(ACmdRdy), 64'h1);

    // Unmapped word read: no ack, no err.
    miso_echo  = 1'b0;
    miso_val   = 64'hFFFF_FFFF_FFFF_FFFF;
    AIoAddrAck = 1'b0;
    AIoAddrErr = 1'b0;
    send(1'b0, 2'd1, 16'h0200, 64'h0);
    step();
    step();
    chk("nr_stat", 64'(ARspStat), 64'h2);
    chk("nr_vld",  64'(ARspVld), 64'h1);
    chk("nr_data", ARspData, 64'hFFFF);
`ifdef IO_INITIATOR_HALT_ON_ERR_EN
    chk("halt_sticky_set", 64'(AErrSticky), 64'h1);
    AIoAddrAck = 1'b1;
    send(1'b0, 2'd0, 16'h0300, 64'h0);
    repeat (3) step();
    chk("halt_no_issue", 64'(AIoRdSize), 64'h0);
    chk("halt_sticky_hold", 64'(AErrSticky), 64'h1);
    clear_halt();
    step();
    chk("halt_resume_issue", 64'(AIoRdSize), 64'h1);
    step();
    chk("halt_resume_stat", 64'(ARspStat), 64'h0);
    chk("halt_resume_vld",  64'(ARspVld), 64'h1);
    step();
`else
    chk("nr_sticky_off", 64'(AErrSticky), 64'h0);
    step();
`endif

    // Error only: size error on a byte write.
    AIoAddrAck = 1'b0;
    AIoAddrErr = 1'b1;
    send(1'b1, 2'd0, 16'h0400, 64'hABCD_EF01);
    step();
    chk("se_wrsize", 64'(AIoWrSize), 64'h1);
    chk("se_mosi",   AIoMosi, 64'h01);
    step();
    chk("se_stat", 64'(ARspStat), 64'h1);
    chk("se_data", ARspData, 64'h0);
    chk("se_wr",   64'(ARspWr), 64'h1);
`ifdef IO_INITIATOR_HALT_ON_ERR_EN
    chk("se_sticky", 64'(AErrSticky), 64'h1);
    clear_halt();
`else
    step();
`endif

    // Ack together with err: protocol violation, qword read.
    AIoAddrAck = 1'b1;
    AIoAddrErr = 1'b1;
    miso_val   = 64'h0123_4567_89AB_CDEF;
    send(1'b0, 2'd3, 16'h0500, 64'h0);
    step();
    step();
    chk("pv_stat", 64'(ARspStat), 64'h3);
    chk("pv_data", ARspData, 64'h0123_4567_89AB_CDEF);
`ifdef IO_INITIATOR_HALT_ON_ERR_EN
    clear_halt();
`else
    step();
`endif
    AIoAddrErr = 1'b0;

    // Clock enable low stretches the access cycle.
    send(1'b1, 2'd3, 16'h0600, 64'h0123_4567_89AB_CDEF);
    step();
    chk("ce_access", 64'(AIoWrSize), 64'h8);
    AClkHEn = 1'b0;
    repeat (3) step();
    chk("ce_hold_size", 64'(AIoWrSize), 64'h8);
    chk("ce_hold_mosi", AIoMosi, 64'h0123_4567_89AB_CDEF);
    chk("ce_no_rsp",    64'(ARspVld), 64'h0);
    AClkHEn = 1'b1;
    step();
    chk("ce_rsp",      64'(ARspVld), 64'h1);
    chk("ce_bus_done", 64'(AIoWrSize), 64'h0);
    step();

    // Reset during an access with two commands still queued.
    ACmdVld  = 1'b1;
    ACmdWr   = 1'b1;
    ACmdSize = 2'd3;
    for (int i = 0; i < 4; i++) begin
      ACmdAddr = 16'h0700 + 16'(i);
      ACmdData = 64'(i + 1);
      step();
    end
    ACmdVld = 1'b0;
    chk("mr_pre_access", 64'(AIoWrSize), 64'h8);
    chk("mr_pre_addr",   64'(AIoAddr), 64'h0701);
    AResetH = 1'b1;
    #1;
    chk("mr_addr",   64'(AIoAddr), 64'h0);
    chk("mr_mosi",   AIoMosi, 64'h0);
    chk("mr_wrsize", 64'(AIoWrSize), 64'h0);
    chk("mr_rdsize", 64'(AIoRdSize), 64'h0);
    chk("mr_vld",    64'(ARspVld), 64'h0);
    chk("mr_rdy",    64'(ACmdRdy), 64'h1);
    repeat (2) step();
    AResetH = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      chk("mr_post_vld",  64'(ARspVld), 64'h0);
      chk("mr_post_wrsz", 64'(AIoWrSize), 64'h0);
    end
    chk("mr_post_rdy", 64'(ACmdRdy), 64'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
